// File: rtl/register_file.sv
// register_file: eight 8-bit general-purpose registers for the CPU datapath.
// One synchronous write port and two independent combinational read ports.
// Asynchronous active-high reset clears every register.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read port that
// addresses the register being written returns the incoming write data
// combinationally (write-through forwarding).
module register_file #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  input  logic              write,
  input  logic              clk,
  input  logic              reset
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int N_READS = 2;

  // Storage keeps its historical name because benches probe it hierarchically.
  logic [WIDTH-1:0] regFile [0:DEPTH-1];

  // Reset clears all entries at once; otherwise write-back data lands in the addressed entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else if (write) begin
      regFile[w_addr] <= in;
    end
  end

  // Both read ports are identical; each gets its own select and data wire.
  genvar gi;
  generate
    for (gi = 0; gi < N_READS; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_sel;
      logic [WIDTH-1:0]  w_data;

      assign w_sel = (gi == 0) ? r_addr1 : r_addr2;

      // Combinational read of the stored value, optionally forwarding this cycle's write.
      always_comb begin
        w_data = regFile[w_sel];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is held off during reset so the outputs stay at the cleared value.
        if (write && !reset && (w_sel == w_addr)) begin
          w_data = in;
        end
`endif
      end
    end
  endgenerate

  assign out1 = g_rd[0].w_data;
  assign out2 = g_rd[1].w_data;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios followed by randomized traffic,
// all checked against a plain array model of the eight registers.
`timescale 1ns/1ps
module tb_register_file;

  logic [7:0] in;
  logic [7:0] out1, out2;
  logic [2:0] w_addr, r_addr1, r_addr2;
  logic       write;
  logic       clk;
  logic       reset;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected contents of each register.
  logic [7:0] model [0:7];

  register_file #(.WIDTH(8), .ADDR_W(3)) dut (
    .in      (in),
    .out1    (out1),
    .out2    (out2),
    .w_addr  (w_addr),
    .r_addr1 (r_addr1),
    .r_addr2 (r_addr2),
    .write   (write),
    .clk     (clk),
    .reset   (reset)
  );

  // 40 ns period leaves room for mid-cycle reset pulses and address sweeps.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, got);
    end
  endtask

  // What a read port should show right now, given the model and current inputs.
  function automatic logic [7:0] exp_read(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    if (write && !reset && a == w_addr) return in;
`endif
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  // One write transaction: drive after the falling edge, capture on the rising edge.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    w_addr = a; in = d; write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    model[a] = d;
  endtask

  initial begin
    in = 8'h00; w_addr = 3'd0; r_addr1 = 3'd0; r_addr2 = 3'd0;
    write = 1'b0; reset = 1'b1;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out1", out1, 8'h00);
    check("reset_out2", out2, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset pulse with no clock edge.
    do_write(3'd2, 8'h0F);
    do_write(3'd5, 8'hAA);
    @(negedge clk);
    #1;
    r_addr1 = 3'd2; r_addr2 = 3'd5;
    #1;
    check("preload_r2", out1, 8'h0F);
    check("preload_r5", out2, 8'hAA);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      r_addr1 = 3'(i); r_addr2 = 3'(7 - i);
      #1;
      check($sformatf("async_rst_out1_a%0d", i), out1, 8'h00);
      check($sformatf("async_rst_out2_a%0d", 7 - i), out2, 8'h00);
    end
    reset = 1'b0;

    // Basic write then read.
    do_write(3'd2, 8'h0F);
    r_addr1 = 3'd2;
    #1;
    check("basic_out1", out1, 8'h0F);
    check("basic_regfile2", dut.regFile[2], 8'h0F);

    // Write enable low: nothing changes.
    @(negedge clk);
    write = 1'b0; w_addr = 3'd3; in = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    check("wen_low_regfile3", dut.regFile[3], 8'h00);

    // Dual read and address swap without a clock.
    do_write(3'd1, 8'h12);
    do_write(3'd7, 8'hFE);
    @(negedge clk);
    r_addr1 = 3'd1; r_addr2 = 3'd7;
    #1;
    check("dual_out1", out1, 8'h12);
    check("dual_out2", out2, 8'hFE);
    r_addr1 = 3'd7; r_addr2 = 3'd1;
    #1;
    check("swap_out1", out1, 8'hFE);
    check("swap_out2", out2, 8'h12);

    // Same-address read during write.
    do_write(3'd4, 8'h33);
    @(negedge clk);
    r_addr2 = 3'd4; w_addr = 3'd4; in = 8'h44; write = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_before_edge", out2, 8'h44);
`else
    check("raw_before_edge", out2, 8'h33);
`endif
    @(posedge clk);
    #1;
    write = 1'b0;
    model[4] = 8'h44;
    #1;
    check("raw_after_edge", out2, 8'h44);

    // Fill all registers then overwrite R0.
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'(8'h10 + i));
    do_write(3'd0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      r_addr1 = 3'(i); r_addr2 = 3'(i);
      #1;
      check($sformatf("fill_out1_r%0d", i), out1, (i == 0) ? 8'hFF : 8'(8'h10 + i));
      check($sformatf("fill_out2_r%0d", i), out2, model[i]);
    end

    // Reset rises while a write is pending: reset wins.
    @(negedge clk);
    w_addr = 3'd6; in = 8'h77; write = 1'b1;
    #2;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_mid_write_regfile6", dut.regFile[6], 8'h00);
    r_addr1 = 3'd6; r_addr2 = 3'd0;
    #1;
    check("rst_mid_write_out1", out1, 8'h00);
    check("rst_mid_write_out2", out2, 8'h00);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      write   = ($urandom_range(0, 3) != 0);
      w_addr  = 3'($urandom_range(0, 7));
      in      = 8'($urandom);
      r_addr1 = 3'($urandom_range(0, 7));
      r_addr2 = ($urandom_range(0, 3) == 0) ? w_addr : 3'($urandom_range(0, 7));
      #1;
      check($sformatf("rnd%0d_pre_out1", n), out1, exp_read(r_addr1));
      check($sformatf("rnd%0d_pre_out2", n), out2, exp_read(r_addr2));
      @(posedge clk);
      if (write) model[w_addr] = in;
      #1;
      write = 1'b0;
      #1;
      check($sformatf("rnd%0d_post_out1", n), out1, model[r_addr1]);
      check($sformatf("rnd%0d_post_out2", n), out2, model[r_addr2]);
    end

    // Final sweep of stored contents.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("final_regfile%0d", i), dut.regFile[i], model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
